// File: rtl/alu_pipe_if.sv
// Issue/result bus between the ALU reservation station, alu_pipe and the CDB arbiter.
// master = RS/CDB side, slave = alu_pipe.
interface alu_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ROB_W = 5
);
  logic              _clear;
  logic              _alu_ready;
  logic [3:0]        _alu_op;
  logic [ROB_W-1:0]  _alu_rob_id;
  logic [XLEN-1:0]   _alu_rs1;
  logic [XLEN-1:0]   _alu_rs2;
  logic              _alu_full;
  logic              _cdb_ready;
  logic [ROB_W-1:0]  _cdb_rob_id;
  logic [XLEN-1:0]   _cdb_value;
  logic              _cdb_grant;

  modport master (
    output _clear, _alu_ready, _alu_op, _alu_rob_id, _alu_rs1, _alu_rs2, _cdb_grant,
    input  _alu_full, _cdb_ready, _cdb_rob_id, _cdb_value
  );

  modport slave (
    input  _clear, _alu_ready, _alu_op, _alu_rob_id, _alu_rs1, _alu_rs2, _cdb_grant,
    output _alu_full, _cdb_ready, _cdb_rob_id, _cdb_value
  );
endinterface

// File: rtl/alu_pipe.sv
// Buffered integer ALU: execute register(s) feeding a tagged result FIFO drained to the CDB.
// Define ALU_PIPE2_EN for a split operand/result register pair (latency 2 instead of 1).
module alu_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ROB_W = 5,
  parameter int unsigned DEPTH = 4
) (
  input logic        clk_in,
  input logic        rst_in,
  input logic        rdy_in,
  alu_pipe_if.slave  bus
);
  localparam int unsigned SHW   = $clog2(XLEN);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [3:0] {
    OpAdd, OpSub, OpSll, OpSlt, OpSltu, OpXor, OpSrl, OpSra,
    OpOr, OpAnd, OpEq, OpNe, OpLt, OpGe, OpLtu, OpGeu
  } op_e;

  function automatic logic [XLEN-1:0] alu_calc(input logic [3:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [SHW-1:0]  shamt;
    logic            lt_s, lt_u, eq, flag;
    logic [XLEN-1:0] res;
    shamt = b[SHW-1:0];
    lt_s  = $signed(a) < $signed(b);
    lt_u  = a < b;
    eq    = a == b;
    flag  = 1'b0;
    res   = '0;
    case (op_e'(op))
      OpAdd:  res = a + b;
      OpSub:  res = a - b;
      OpSll:  res = a << shamt;
      OpSlt:  flag = lt_s;
      OpSltu: flag = lt_u;
      OpXor:  res = a ^ b;
      OpSrl:  res = a >> shamt;
      OpSra:  res = $unsigned($signed(a) >>> shamt);
      OpOr:   res = a | b;
      OpAnd:  res = a & b;
      OpEq:   flag = eq;
      OpNe:   flag = !eq;
      OpLt:   flag = lt_s;
      OpGe:   flag = !lt_s;
      OpLtu:  flag = lt_u;
      OpGeu:  flag = !lt_u;
      default: res = '0;
    endcase
    // Compare opcodes leave res at zero, so OR-ing in the flag zero-extends it.
    return res | {{(XLEN-1){1'b0}}, flag};
  endfunction

  logic                   accept, push, pop, cdb_ready;
  logic [CNT_W-1:0]       occupancy;
  logic                   ex_valid_q;
  logic [ROB_W-1:0]       ex_tag_q;
  logic [XLEN-1:0]        ex_result_q;
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       count_q;
  logic [ROB_W+XLEN-1:0]  mem_q [DEPTH];
  logic [ROB_W+XLEN-1:0]  head;

`ifdef ALU_PIPE2_EN
  logic                   s1_valid_q;
  logic [3:0]             s1_op_q;
  logic [ROB_W-1:0]       s1_tag_q;
  logic [XLEN-1:0]        s1_rs1_q, s1_rs2_q;
`endif

  always_comb begin
    occupancy = count_q + CNT_W'(ex_valid_q);
`ifdef ALU_PIPE2_EN
    occupancy = occupancy + CNT_W'(s1_valid_q);
`endif
  end

  // Full is derived from counts alone so it never loops back through issue or grant.
  assign bus._alu_full = occupancy >= CNT_W'(DEPTH - 1);

  assign cdb_ready = count_q != '0;
  assign accept    = bus._alu_ready && !bus._alu_full && rdy_in && !bus._clear;
  assign push      = ex_valid_q && rdy_in && !bus._clear && !rst_in;
  assign pop       = cdb_ready && bus._cdb_grant && rdy_in;

  always_ff @(posedge clk_in) begin
    if (rst_in || bus._clear) begin
      ex_valid_q <= 1'b0;
`ifdef ALU_PIPE2_EN
      s1_valid_q <= 1'b0;
`endif
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else if (rdy_in) begin
`ifdef ALU_PIPE2_EN
      s1_valid_q <= accept;
      if (accept) begin
        s1_op_q  <= bus._alu_op;
        s1_tag_q <= bus._alu_rob_id;
        s1_rs1_q <= bus._alu_rs1;
        s1_rs2_q <= bus._alu_rs2;
      end
      ex_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        ex_tag_q    <= s1_tag_q;
        ex_result_q <= alu_calc(s1_op_q, s1_rs1_q, s1_rs2_q);
      end
`else
      ex_valid_q <= accept;
      if (accept) begin
        ex_tag_q    <= bus._alu_rob_id;
        ex_result_q <= alu_calc(bus._alu_op, bus._alu_rs1, bus._alu_rs2);
      end
`endif
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= {ex_tag_q, ex_result_q};
  end

  assign head             = mem_q[rd_ptr_q];
  assign bus._cdb_ready   = cdb_ready;
  assign bus._cdb_rob_id  = cdb_ready ? head[ROB_W+XLEN-1:XLEN] : '0;
  assign bus._cdb_value   = cdb_ready ? head[XLEN-1:0] : '0;
endmodule
